// File: rtl/pic_pkg.sv
// Shared types for the PIC interrupt sequencer: FSM states, OCW2 codes
// and the rotating-priority helper.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } pic_state_t;

  localparam logic [2:0] CMD_NS_EOI   = 3'b001;
  localparam logic [2:0] CMD_SP_EOI   = 3'b011;
  localparam logic [2:0] CMD_ROT_NS   = 3'b101;
  localparam logic [2:0] CMD_ROT_SP   = 3'b111;
  localparam logic [2:0] CMD_SET_PRIO = 3'b110;
  localparam logic [2:0] CMD_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_AEOI_CLR = 3'b000;

  // Rotate vec so bit 0 holds the highest-priority level
  // (lowest_prio + 1 mod 8).
  function automatic logic [7:0] rot_prio_first(
    input logic [7:0] vec,
    input logic [2:0] lowest_prio
  );
    logic [15:0] d;
    d = {vec, vec} >> ({1'b0, lowest_prio} + 4'd1);
    return d[7:0];
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating priority encoder.
// Ports: vec/lowest_prio in; valid/level out (highest-priority set bit).
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lowest_prio,
  output logic       valid,
  output logic [2:0] level
);

  logic [7:0] rot;
  logic [2:0] idx;

  always_comb begin
    rot = rot_prio_first(vec, lowest_prio);
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) idx = 3'(i);
    end
    valid = |vec;
    level = idx + lowest_prio + 3'd1;
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259-style interrupt core: IRR/ISR, priority, INT/INTA sequence, OCW2.
// Ports: clk, rst_n, IR, IMR, mode/cmd inputs, INTA_n; INT, int_flag,
// vector_out, status_out, IRR, ISR. Option macro: PIC_ROTATION_EN.
module pic_interrupt_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR     = 8,
  parameter int SPUR_LEVEL = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IR,
  input  logic [7:0] IMR,
  input  logic       LTIM,
  input  logic       EOI_mode,
  input  logic [4:0] VEC_ADD,
  input  logic [2:0] EOI_command,
  input  logic [2:0] int_level,
  input  logic       EOI_command_updated,
  input  logic       read_mode,
  input  logic       INTA_n,
  output logic       INT,
  output logic       int_flag,
  output logic [7:0] vector_out,
  output logic [7:0] status_out,
  output logic [7:0] IRR,
  output logic [7:0] ISR
);

  if (NUM_IR != 8) begin : g_num_ir_chk
    $error("NUM_IR must be 8");
  end

  pic_state_t state_q, state_d;
  logic [7:0] ir_q, irr_q, irr_d, isr_q, isr_d, vec_q, vec_d;
  logic [7:0] eoi_clr;
  logic       inta_q, tog_q;
  logic       int_q, int_d, flag_q, flag_d, spur_q, spur_d;
  logic [2:0] lvl_q, lvl_d;
  logic [2:0] lowest_prio;

`ifdef PIC_ROTATION_EN
  logic [2:0] lp_q, lp_d;
  logic       ra_q, ra_d;
  assign lowest_prio = lp_q;
`else
  assign lowest_prio = 3'd7;
`endif

  logic       cand_valid, top_valid, winner;
  logic [2:0] cand_lvl, top_lvl, cand_rank, top_rank;
  logic       inta_fall, inta_rise, cmd_pulse;

  pic_priority_resolver u_req (
    .vec         (irr_q & ~IMR),
    .lowest_prio (lowest_prio),
    .valid       (cand_valid),
    .level       (cand_lvl)
  );

  pic_priority_resolver u_svc (
    .vec         (isr_q),
    .lowest_prio (lowest_prio),
    .valid       (top_valid),
    .level       (top_lvl)
  );

  // Rank 0 = highest priority under the current rotation.
  assign cand_rank = cand_lvl - lowest_prio - 3'd1;
  assign top_rank  = top_lvl - lowest_prio - 3'd1;
  assign winner    = cand_valid &&
                     (!top_valid || cand_rank < top_rank);

  assign inta_fall = inta_q & ~INTA_n;
  assign inta_rise = ~inta_q & INTA_n;
  assign cmd_pulse = EOI_command_updated ^ tog_q;

  always_comb begin
    state_d = state_q;
    irr_d   = LTIM ? IR : (irr_q | (IR & ~ir_q));
    int_d   = int_q;
    flag_d  = flag_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    eoi_clr = 8'h00;
`ifdef PIC_ROTATION_EN
    lp_d    = lp_q;
    ra_d    = ra_q;
`endif
    if (cmd_pulse) begin
      case (EOI_command)
        CMD_NS_EOI: begin
          if (top_valid) eoi_clr = 8'h01 << top_lvl;
        end
        CMD_SP_EOI: eoi_clr = 8'h01 << int_level;
        CMD_ROT_NS: begin
          if (top_valid) begin
            eoi_clr = 8'h01 << top_lvl;
`ifdef PIC_ROTATION_EN
            lp_d = top_lvl;
`endif
          end
        end
        CMD_ROT_SP: begin
          eoi_clr = 8'h01 << int_level;
`ifdef PIC_ROTATION_EN
          lp_d = int_level;
`endif
        end
        CMD_SET_PRIO: begin
`ifdef PIC_ROTATION_EN
          lp_d = int_level;
`endif
        end
        CMD_AEOI_SET: begin
`ifdef PIC_ROTATION_EN
          ra_d = 1'b1;
`endif
        end
        CMD_AEOI_CLR: begin
`ifdef PIC_ROTATION_EN
          ra_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end
    // EOI target comes from pre-update ISR; a same-cycle ACK1 set wins.
    isr_d = isr_q & ~eoi_clr;
    unique case (state_q)
      IDLE: begin
        int_d = winner;
        if (inta_fall) begin
          int_d   = 1'b0;
          state_d = ACK1;
          if (winner) begin
            isr_d[cand_lvl] = 1'b1;
            irr_d[cand_lvl] = 1'b0;
            lvl_d  = cand_lvl;
            spur_d = 1'b0;
          end else begin
            lvl_d  = 3'(SPUR_LEVEL);
            spur_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_fall) begin
          flag_d  = 1'b1;
          vec_d   = {VEC_ADD, lvl_q};
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          flag_d  = 1'b0;
          state_d = IDLE;
          if (EOI_mode && !spur_q) begin
            isr_d[lvl_q] = 1'b0;
`ifdef PIC_ROTATION_EN
            if (ra_q) lp_d = lvl_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= 8'h00;
      irr_q   <= 8'h00;
      isr_q   <= 8'h00;
      vec_q   <= 8'h00;
      inta_q  <= 1'b1;
      tog_q   <= 1'b0;
      int_q   <= 1'b0;
      flag_q  <= 1'b0;
      spur_q  <= 1'b0;
      lvl_q   <= 3'd0;
`ifdef PIC_ROTATION_EN
      lp_q    <= 3'd7;
      ra_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= IR;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      vec_q   <= vec_d;
      inta_q  <= INTA_n;
      tog_q   <= EOI_command_updated;
      int_q   <= int_d;
      flag_q  <= flag_d;
      spur_q  <= spur_d;
      lvl_q   <= lvl_d;
`ifdef PIC_ROTATION_EN
      lp_q    <= lp_d;
      ra_q    <= ra_d;
`endif
    end
  end

  assign INT        = int_q;
  assign int_flag   = flag_q;
  assign vector_out = vec_q;
  assign IRR        = irr_q;
  assign ISR        = isr_q;
  assign status_out = read_mode ? isr_q : irr_q;

endmodule
